imem_loader: RTL

Instruction-memory responder on the CPU side opposite the MCU fetch path: it supplies imem_data for every imem_addr the pc presents. Before execution it receives a program over a byte-wide valid/ready stream, stores it, then releases the CPU from hold. It replaces the bench-driven imem_data stimulus with a real, reloadable program store.

---
 rtl/imem_loader_pkg.sv | 25 ++
 rtl/imem_loader_ram.sv | 33 +++
 rtl/imem_loader.sv | 115 +++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
// Holds the loader state encoding, the default fill value returned for
// unloaded addresses, and the MCU opcode values used to build programs.
package imem_loader_pkg;

    localparam int INST_WIDTH = 8;
    localparam int INST_DEPTH = 256;
    localparam int ADDR_WIDTH = 8;

    localparam logic [INST_WIDTH-1:0] IMEM_FILL = 8'h00;

    // MCU opcodes (program content only; the loader never decodes them)
    localparam logic [INST_WIDTH-1:0] MCU_LOAD = 8'h01;
    localparam logic [INST_WIDTH-1:0] MCU_ADD  = 8'h02;
    localparam logic [INST_WIDTH-1:0] MCU_SUB  = 8'h03;
    localparam logic [INST_WIDTH-1:0] MCU_JUMP = 8'h04;

    typedef enum logic [1:0] {
        IMEM_IDLE = 2'b00,
        IMEM_LOAD = 2'b01,
        IMEM_RUN  = 2'b10,
        IMEM_ERR  = 2'b11
    } imem_state_t;

endpackage

// File: rtl/imem_loader_ram.sv
// Program store: DEPTH x INST_WIDTH, one synchronous write port and one
// asynchronous read port. Contents are not reset.
// Ports:
//   clk      - write clock
//   wr_en    - write strobe
//   wr_addr  - write address
//   wr_data  - write data
//   rd_addr  - read address (combinational)
//   rd_data  - read data
module imem_loader_ram #(
    parameter int INST_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [INST_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [INST_WIDTH-1:0] rd_data
);

    logic [INST_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/imem_loader.sv
// Reloadable instruction memory. A program arrives as a byte stream over
// valid/ready, is stored in imem_loader_ram, and the CPU is then released
// from hold. In RUN the pc's address is answered combinationally.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | after reset, no program, CPU held
//   LOAD  | accepting stream bytes, CPU held
//   RUN   | program valid, CPU released, reads served
//   ERR   | stream overran DEPTH without load_last, CPU held
//
// Ports:
//   clk, rst         - clock, asynchronous active-low reset
//   load_start       - pulse, begin or restart a load
//   load_valid/data/last, load_ready - byte stream
//   imem_addr/imem_data - fetch port (zero-cycle latency)
//   cpu_hold         - registered, low only in RUN
//   prog_len         - bytes stored by the last load
//   load_err         - sticky overflow flag for the current load
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int                     INST_WIDTH = 8,
    parameter int                     ADDR_WIDTH = 8,
    parameter int                     DEPTH      = 256,
    parameter logic [INST_WIDTH-1:0]  FILL       = IMEM_FILL
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [INST_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  load_ready,
    input  logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [INST_WIDTH-1:0] imem_data,
    output logic                  cpu_hold,
    output logic [ADDR_WIDTH:0]   prog_len,
    output logic                  load_err
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] PTR_LAST = (ADDR_WIDTH+1)'(DEPTH-1);

    imem_state_t           state;
    logic [ADDR_WIDTH:0]   wptr;
    logic                  beat;
    logic                  rd_hit;
    logic [INST_WIDTH-1:0] rd_data;

    // A restart request has priority over a byte presented in the same cycle.
    assign load_ready = (state == IMEM_LOAD) && !load_start;
    assign beat       = load_valid && load_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IMEM_IDLE;
            wptr     <= '0;
            prog_len <= '0;
            load_err <= 1'b0;
            cpu_hold <= 1'b1;
        end else begin
            case (state)
                IMEM_IDLE, IMEM_RUN, IMEM_ERR: begin
                    if (load_start) begin
                        state    <= IMEM_LOAD;
                        wptr     <= '0;
                        prog_len <= '0;
                        load_err <= 1'b0;
                        cpu_hold <= 1'b1;
                    end
                end
                IMEM_LOAD: begin
                    if (load_start) begin
                        wptr     <= '0;
                        prog_len <= '0;
                    end else if (beat) begin
                        wptr     <= wptr + PTR_ONE;
                        prog_len <= wptr + PTR_ONE;
                        if (load_last) begin
                            state    <= IMEM_RUN;
                            cpu_hold <= 1'b0;
                        end else if (wptr == PTR_LAST) begin
                            state    <= IMEM_ERR;
                            load_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IMEM_IDLE;
                    cpu_hold <= 1'b1;
                end
            endcase
        end
    end

    imem_loader_ram #(
        .INST_WIDTH (INST_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (beat),
        .wr_addr (wptr[ADDR_WIDTH-1:0]),
        .wr_data (load_data),
        .rd_addr (imem_addr),
        .rd_data (rd_data)
    );

    // prog_len never exceeds DEPTH, so this compare also masks addresses
    // beyond the physical array.
    assign rd_hit    = (state == IMEM_RUN) && ({1'b0, imem_addr} < prog_len);
    assign imem_data = rd_hit ? rd_data : FILL;

endmodule
